// File: rtl/processor_nios2_qsys_0_oci_dct_packer_pkg.sv
// Shared constants and state encoding for the OCI DCT packer slice.
// Optional feature macro used by the top: DCT_STALL_CNT_EN.
package processor_nios2_qsys_0_oci_dct_packer_pkg;

    localparam int unsigned DCT_SYM_W = 2;
    localparam int unsigned DCT_DEPTH = 15;
    localparam int unsigned DCT_CNT_W = 4;
    localparam int unsigned DCT_BUF_W = DCT_SYM_W * DCT_DEPTH;
    localparam int unsigned DCT_OUT_W = DCT_CNT_W + DCT_BUF_W;

    // out_data = {count, buffer}
    localparam int unsigned OUT_BUF_LSB = 0;
    localparam int unsigned OUT_BUF_MSB = DCT_BUF_W - 1;
    localparam int unsigned OUT_CNT_LSB = DCT_BUF_W;
    localparam int unsigned OUT_CNT_MSB = DCT_OUT_W - 1;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StEnded = 2'd2
    } dct_state_e;

endpackage

// File: rtl/processor_nios2_qsys_0_oci_dct_slot.sv
// One-entry valid/ready holding register between the packer and trace memory.
// The word stays stable while out_valid && !out_ready.
module processor_nios2_qsys_0_oci_dct_slot
    import processor_nios2_qsys_0_oci_dct_packer_pkg::*;
#(
    parameter int unsigned WIDTH = DCT_OUT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             slot_free
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign slot_free = !r_valid || out_ready;

endmodule

// File: rtl/processor_nios2_qsys_0_oci_dct_packer.sv
// OCI DCT trace packer: shifts symbols into a buffer, hands full/flushed words to the slot,
// and runs the test_ending drain sequence. Define DCT_STALL_CNT_EN to add stall_count.
module processor_nios2_qsys_0_oci_dct_packer
    import processor_nios2_qsys_0_oci_dct_packer_pkg::*;
#(
    parameter int unsigned SYM_W = DCT_SYM_W,
    parameter int unsigned DEPTH = DCT_DEPTH,
    parameter int unsigned CNT_W = DCT_CNT_W,
    localparam int unsigned BUF_W = SYM_W * DEPTH
) (
`ifdef DCT_STALL_CNT_EN
    output logic [15:0]            stall_count,
`endif
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   tr_valid,
    input  logic [SYM_W-1:0]       tr_data,
    output logic                   tr_ready,
    input  logic                   flush,
    input  logic                   test_ending,
    output logic                   test_has_ended,
    output logic [BUF_W-1:0]       dct_buffer,
    output logic [CNT_W-1:0]       dct_count,
    output logic                   out_valid,
    output logic [CNT_W+BUF_W-1:0] out_data,
    input  logic                   out_ready
);

    dct_state_e       r_state, w_state_nxt;
    logic [BUF_W-1:0] r_buffer, w_buffer_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_flush_pending, w_flush_nxt;
    logic             r_alive;

    logic w_slot_free, w_full, w_has_data, w_accept, w_transfer;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_has_data = (r_count != '0);
    // r_alive holds intake closed for the first cycle after reset release.
    assign tr_ready   = r_alive && (r_state == StRun) && (!w_full || w_slot_free);
    assign w_accept   = tr_valid && tr_ready;
    assign w_transfer = w_slot_free &&
                        (w_full || ((r_flush_pending || (r_state == StDrain)) && w_has_data));

    always_comb begin
        w_buffer_nxt = r_buffer;
        w_count_nxt  = r_count;
        if (w_transfer) begin
            if (w_accept) begin
                w_buffer_nxt = {{(BUF_W-SYM_W){1'b0}}, tr_data};
                w_count_nxt  = CNT_W'(1);
            end else begin
                w_buffer_nxt = '0;
                w_count_nxt  = '0;
            end
        end else if (w_accept) begin
            w_buffer_nxt = {r_buffer[BUF_W-SYM_W-1:0], tr_data};
            w_count_nxt  = r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_flush_nxt = r_flush_pending;
        if (w_transfer || !w_has_data) begin
            w_flush_nxt = 1'b0;
        end
        if (flush && (r_state == StRun)) begin
            w_flush_nxt = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StRun:   if (test_ending) w_state_nxt = StDrain;
            StDrain: if (!w_has_data && !out_valid) w_state_nxt = StEnded;
            StEnded: w_state_nxt = StEnded;
            default: w_state_nxt = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= StRun;
            r_buffer        <= '0;
            r_count         <= '0;
            r_flush_pending <= 1'b0;
            r_alive         <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_buffer        <= w_buffer_nxt;
            r_count         <= w_count_nxt;
            r_flush_pending <= w_flush_nxt;
            r_alive         <= 1'b1;
        end
    end

    processor_nios2_qsys_0_oci_dct_slot #(
        .WIDTH(CNT_W + BUF_W)
    ) u_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (w_transfer),
        .load_data ({r_count, r_buffer}),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .slot_free (w_slot_free)
    );

    assign dct_buffer     = r_buffer;
    assign dct_count      = r_count;
    assign test_has_ended = (r_state == StEnded);

`ifdef DCT_STALL_CNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_count <= '0;
        end else if ((r_state == StRun) && tr_valid && !tr_ready &&
                     (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_processor_nios2_qsys_0_oci_dct_packer.sv
// Scoreboard bench for the OCI DCT packer: directed stimulus pushes expected words,
// a negedge monitor pops and compares each word as it leaves the output slot.
module tb_processor_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tr_valid = 1'b0;
    logic [1:0]  tr_data = 2'b00;
    logic        tr_ready;
    logic        flush = 1'b0;
    logic        test_ending = 1'b0;
    logic        test_has_ended;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        out_valid;
    logic [33:0] out_data;
    logic        out_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [33:0] exp_q[$];
    logic [33:0] exp_w;
    logic [33:0] held_word;

    processor_nios2_qsys_0_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .tr_valid       (tr_valid),
        .tr_data        (tr_data),
        .tr_ready       (tr_ready),
        .flush          (flush),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every word that transfers out must match the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_word_unexpected: got %h, expected no word", out_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (out_data !== exp_w) begin
                    errors++;
                    $display("FAIL out_word: got %h, expected %h", out_data, exp_w);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s);
        bit ok;
        ok = 1'b0;
        tr_valid = 1'b1;
        tr_data  = s;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (tr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        tr_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [1:0] s);
        for (int i = 0; i < n; i++) send(s);
    endtask

    task automatic reset_and_check();
        reset_n = 1'b0;
        #3;
        chk("rst_count", 64'(dct_count), 64'd0);
        chk("rst_buffer", 64'(dct_buffer), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_tr_ready", 64'(tr_ready), 64'd0);
        chk("rst_ended", 64'(test_has_ended), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_release_tr_ready_low", 64'(tr_ready), 64'd0);
        @(negedge clk);
        chk("rst_release_tr_ready_high", 64'(tr_ready), 64'd1);
        step(1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
    endtask

    initial begin
        reset_and_check();

        // Basic fill
        out_ready = 1'b1;
        exp_q.push_back({4'd15, 30'h15555555});
        send_n(15, 2'b01);
        @(negedge clk);
        chk("fill_count_full", 64'(dct_count), 64'd15);
        @(negedge clk);
        chk("fill_count_cleared", 64'(dct_count), 64'd0);
        chk("fill_out_valid", 64'(out_valid), 64'd1);
        step(2);

        // Backpressure: 30 symbols into a blocked slot
        out_ready = 1'b0;
        send_n(15, 2'b10);
        send_n(15, 2'b11);
        tr_valid = 1'b1;
        tr_data  = 2'b00;
        @(negedge clk);
        chk("bp_tr_ready_low", 64'(tr_ready), 64'd0);
        chk("bp_count_full", 64'(dct_count), 64'd15);
        chk("bp_buffer", 64'(dct_buffer), 64'h3FFFFFFF);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_out_data", 64'(out_data), 64'({4'd15, 30'h2AAAAAAA}));
        held_word = {4'd15, 30'h2AAAAAAA};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_data_stable", 64'(out_data), 64'(held_word));
        end
        step(1);
        tr_valid = 1'b0;
        exp_q.push_back({4'd15, 30'h2AAAAAAA});
        exp_q.push_back({4'd15, 30'h3FFFFFFF});
        out_ready = 1'b1;
        step(3);
        chk("bp_count_drained", 64'(dct_count), 64'd0);
        chk("bp_queue_drained", 64'(exp_q.size()), 64'd0);

        // Flush partial, then flush of an empty buffer
        exp_q.push_back({4'd3, 30'h39});
        send(2'b11);
        send(2'b10);
        send(2'b01);
        pulse_flush();
        step(3);
        chk("flush_count_cleared", 64'(dct_count), 64'd0);
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_empty_no_word", 64'(out_valid), 64'd0);
        end
        step(1);

        // 15th symbol coincident with flush: one word only
        exp_q.push_back({4'd15, 30'h15555555});
        send_n(14, 2'b01);
        tr_valid = 1'b1;
        tr_data  = 2'b01;
        flush    = 1'b1;
        @(negedge clk);
        chk("coinc_tr_ready", 64'(tr_ready), 64'd1);
        step(1);
        tr_valid = 1'b0;
        flush    = 1'b0;
        step(4);
        chk("coinc_count", 64'(dct_count), 64'd0);

        // Transfer cycle plus new symbol
        exp_q.push_back({4'd15, 30'h2AAAAAAA});
        send_n(15, 2'b10);
        send(2'b11);
        @(negedge clk);
        chk("coinc_new_count", 64'(dct_count), 64'd1);
        chk("coinc_new_buffer", 64'(dct_buffer), 64'h3);
        exp_q.push_back({4'd1, 30'h3});
        step(1);
        pulse_flush();
        step(3);

        // Drain sequence
        out_ready = 1'b0;
        exp_q.push_back({4'd7, 30'h1B1B});
        send(2'b01);
        send(2'b10);
        send(2'b11);
        send(2'b00);
        send(2'b01);
        send(2'b10);
        send(2'b11);
        test_ending = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("drain_tr_ready_low", 64'(tr_ready), 64'd0);
        @(negedge clk);
        chk("drain_out_valid", 64'(out_valid), 64'd1);
        chk("drain_count_cleared", 64'(dct_count), 64'd0);
        step(2);
        chk("drain_not_ended_yet", 64'(test_has_ended), 64'd0);
        out_ready = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (test_has_ended) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("drain_ended", 64'(seen), 64'd1);
        end
        step(1);
        test_ending = 1'b0;
        step(3);
        chk("ended_sticky", 64'(test_has_ended), 64'd1);
        chk("ended_tr_ready", 64'(tr_ready), 64'd0);

        // Reset mid-fill with a word held in the slot
        reset_and_check();
        out_ready = 1'b0;
        send_n(24, 2'b01);
        @(negedge clk);
        chk("midrst_count", 64'(dct_count), 64'd9);
        chk("midrst_buffer", 64'(dct_buffer), 64'h15555);
        chk("midrst_out_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_async_count", 64'(dct_count), 64'd0);
        chk("midrst_async_buffer", 64'(dct_buffer), 64'd0);
        chk("midrst_async_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_async_out_data", 64'(out_data), 64'd0);
        chk("midrst_async_tr_ready", 64'(tr_ready), 64'd0);
        step(2);
        reset_n = 1'b1;
        step(3);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/processor_nios2_qsys_0_oci_dct_packer.md
Name: processor_nios2_qsys_0_oci_dct_packer

Overview:
- Sequencing controller for the OCI debug capture trace (DCT) buffer.
- Packs 2-bit trace symbols into a 30-bit shift buffer with a 4-bit fill count.
- Hands full or flushed buffers to the trace memory through a one-entry valid/ready output slot.
- Drives the test_ending/test_has_ended drain sequence consumed by the OCI test bench.

Parameters:
- SYM_W, 2: bits per trace symbol.
- DEPTH, 15: symbols per buffer; buffer width BUF_W = SYM_W*DEPTH = 30.
- CNT_W, 4: fill-count width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk, in, 1: single clock; all state on rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- tr_valid, in, 1: trace symbol offered.
- tr_data, in, SYM_W: trace symbol.
- tr_ready, out, 1: symbol accepted when tr_valid && tr_ready.
- flush, in, 1: single-cycle pulse; emit the partial buffer.
- test_ending, in, 1: level; stop intake, drain, end.
- test_has_ended, out, 1: drain complete; sticky until reset.
- dct_buffer, out, BUF_W: live packing buffer.
- dct_count, out, CNT_W: live fill count, 0..DEPTH.
- out_valid, out, 1: output slot holds a word.
- out_data, out, CNT_W+BUF_W: {count, buffer} captured at transfer.
- out_ready, in, 1: downstream accepts when out_valid && out_ready.

Behaviour:
- Reset: all outputs 0, state RUN, flush_pending 0. tr_ready is 0 during reset and returns to 1 one cycle after reset_n deasserts.
- States:
  - RUN: normal packing.
  - DRAIN: intake closed, emit remainder.
  - ENDED: idle, test_has_ended=1.
- Accept: buffer <= {buffer[BUF_W-SYM_W-1:0], tr_data}; newest symbol at LSBs; count +1.
- slot_free = !out_valid || out_ready.
- Transfer fires when slot_free and either:
  - count==DEPTH, or
  - (flush_pending || state==DRAIN) && count>0.
- On transfer:
  - out_data <= {count, buffer}; out_valid <= 1.
  - Buffer and count clear. If a symbol is accepted the same cycle, it becomes the only content (buffer={0,tr_data}, count=1).
  - flush_pending clears.
- tr_ready = (state==RUN) && (count!=DEPTH || slot_free). A full buffer with a blocked slot stalls intake; no symbol is ever dropped.
- out_valid clears on out_ready when no new transfer occurs; back-to-back transfers are allowed. out_data is stable while out_valid && !out_ready.
- Latency: symbol accepted at cycle N appears in dct_buffer at N+1. The transfer of a full buffer is visible on out_valid at N+1 when the slot is free.
- Flush:
  - Pulse sets flush_pending.
  - If count==0 when evaluated, flush_pending clears with no word emitted.
  - Flush coinciding with the 15th symbol produces one word only.
- test_ending high in RUN moves to DRAIN next cycle; a symbol accepted in that same cycle is kept.
- DRAIN:
  - Emits the remainder if count>0.
  - Moves to ENDED when count==0 and !out_valid.
  - flush is ignored.
- ENDED: test_has_ended=1, tr_ready=0. Only reset exits, even if test_ending drops.
- Reset mid-operation discards the buffer, count and any pending slot word immediately.

Optional Feature:
- DCT_STALL_CNT_EN defined:
  - Adds output stall_count[15:0].
  - Counts cycles with tr_valid && !tr_ready while state==RUN.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package/include holds:
  - state encoding (RUN=2'd0, DRAIN=2'd1, ENDED=2'd2);
  - default SYM_W/DEPTH/CNT_W constants;
  - the out_data field-position constants.
- One sub-module: processor_nios2_qsys_0_oci_dct_slot.
  - One-entry valid/ready holding register, width CNT_W+BUF_W.
  - Ports: load, load_data, out_valid, out_data, out_ready, slot_free.

Test Plan:
- Basic fill: 15 consecutive symbols 2'b01, out_ready=1 -> one word, out_data={4'd15, 30'h15555555}, dct_count back to 0 the cycle after.
- Backpressure: out_ready=0, 30 symbols offered -> first word held stable; second buffer fills to 15; tr_ready=0. Raise out_ready -> second word follows next cycle; no symbol lost.
- Flush partial: 3 symbols 2'b11, 2'b10, 2'b01 then flush -> out_data={4'd3, 30'h39}. A flush with count 0 produces no out_valid.
- Coincident events: 15th symbol plus flush same cycle -> exactly one word. Transfer cycle plus new symbol -> dct_count=1.
- Drain: 7 symbols, then test_ending=1 -> tr_ready=0 next cycle, word with count 7 emitted. test_has_ended=1 after out_ready, stays 1 after test_ending drops.
- Reset mid-fill: reset_n low with count=9 and out_valid=1 -> all outputs 0 asynchronously. With DCT_STALL_CNT_EN, stall_count also clears.
